stream_sel_mux: RTL and testbench
=================================

// Module: stream_sel_mux
// PURPOSE
//  Parametrised N:1 stream selector with a registered output stage and valid/ready handshake.
//  Picks one of N producer channels by external select (MODE=0) or fair round-robin arbitration (MODE=1).
//  Registers the chosen beat with its source index. Carries WIDTH-bit data between pipeline
//  stages: writeback-source merge, multi-master bus front end, N-to-1 trace/debug port.
// PARAMETERS
//  WIDTH  32  data width per channel
//  N      8   channel count, 2..32; need not be a power of two
//  SEL_W  $clog2(N)  select/index width (derived, do not override)
//  MODE   0   0 = external select via sel; 1 = round-robin arbitration, sel ignored
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   N        per-channel beat valid
//  in_data    in   N*WIDTH  channel i at [i*WIDTH +: WIDTH]
//  in_ready   out  N        per-channel accept, combinational, one-hot or zero
//  sel        in   SEL_W    channel select (MODE=0 only)
//  lock       in   1        sampled with accepted beat: hold grant on same channel
//  out_valid  out  1        output register holds a beat
//  out_data   out  WIDTH    registered beat data
//  out_src    out  SEL_W    channel index of out_data
//  out_ready  in   1        consumer accept
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, rr_ptr=0, locked=0.
//    in_ready=0 while rst_n=0.
//  - Output register load enable: ld = !out_valid | out_ready.
//  - Grant candidate g:
//    - MODE=0: g=sel if sel<N and in_valid[sel]; otherwise no grant.
//    - MODE=1: first valid channel scanning rr_ptr, rr_ptr+1, ... N-1, 0, ... (mod N).
//    - locked=1 (either mode): g = lock_src only; wait until in_valid[lock_src], no other channel granted.
//  - in_ready[g] = ld & grant_exists; all other bits 0. Transfer = in_valid[g] & in_ready[g].
//  - On transfer: out_data <= in_data[g], out_src <= g, out_valid <= 1.
//    MODE=1 and lock=0: rr_ptr <= (g==N-1) ? 0 : g+1.
//    lock=1: locked <= 1, lock_src <= g, rr_ptr unchanged.
//    lock=0: locked <= 0.
//  - out_ready=1 with no transfer: out_valid <= 0. out_data/out_src hold last value.
//  - out_valid=1 & out_ready=0: register holds; in_ready all 0 (stall, no beat dropped or duplicated).
//  - Latency: 1 cycle input to output. Full throughput of 1 beat/cycle while out_ready=1.
//  - sel >= N (non-power-of-2 N): no grant, no X propagation, state unchanged.
//  - sel changing while stalled: no effect until ld=1; grant is re-evaluated every cycle.
//  - Reset mid-transfer: beat discarded, lock cleared, pointer returns to 0.
// STRUCTURE
//  - Shared package: stream_pkg.
//    - MODE_SEL=0, MODE_RR=1 localparams.
//    - Function rr_next(ptr, n) for modular increment.
//  - One sub-module: rr_pick #(N) (combinational).
//    - Inputs: req[N], ptr[SEL_W].
//    - Outputs: gnt_idx[SEL_W], gnt_any. Implemented as double-width masked priority encode.
//  - Top level holds the registers: out regs, rr_ptr, locked, lock_src.
//  - Grant mux: indexed part-select, no case tables.
// TESTING
//  1. MODE=0, N=8, WIDTH=32; sel=5, in_valid=8'h20, in_data[5]=32'hDEADBEEF, out_ready=1
//     -> next cycle out_valid=1, out_data=DEADBEEF, out_src=5; in_ready=8'h20 during accept.
//  2. MODE=1, all 8 channels valid each cycle, out_ready=1 for 16 cycles
//     -> out_src sequence 0,1,...,7,0,...,7; no repeats or skips.
//  3. Backpressure: out_valid=1, out_ready=0 for 3 cycles with new inputs
//     -> out_data stable, in_ready=0; first cycle out_ready=1 accepts exactly one new beat.
//  4. lock: MODE=1, ch2 accepted with lock=1, ch2 then idle 2 cycles, ch3 valid
//     -> ch3 not granted; ch2 next beat with lock=0 granted; then rr_ptr=3 and ch3 wins.
//  5. N=5, MODE=0, sel=6, in_valid=5'h1F -> in_ready=0, out_valid stays 0, no X on outputs.
//  6. rst_n pulsed low mid-stream with out_valid=1, locked=1
//     -> outputs 0 immediately (async); after release, round-robin resumes from channel 0.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared definitions for the stream selector: mode encodings and the
// modular round-robin pointer increment.
package stream_pkg;

   localparam int unsigned MODE_SEL = 0;
   localparam int unsigned MODE_RR  = 1;

   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return (ptr >= n - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/stream_sel_mux_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N, found by a priority encode over a doubled request vector.
module rr_pick #(
   parameter int unsigned N     = 8,
   parameter int unsigned SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_any
);

   logic [2*N-1:0] req2;
   logic [2*N-1:0] masked;
   int unsigned    pos;

   always_comb begin
      req2   = {req, req};
      masked = '0;
      for (int unsigned i = 0; i < 2*N; i++) begin
         masked[i] = req2[i] && (i >= 32'(ptr));
      end
   end

   // Scan downwards so the lowest masked position wins; the upper copy
   // supplies the wrapped-around channels below ptr.
   always_comb begin
      pos     = 0;
      gnt_any = 1'b0;
      for (int unsigned i = 2*N; i > 0; i--) begin
         if (masked[i-1]) begin
            pos     = i - 1;
            gnt_any = 1'b1;
         end
      end
      gnt_idx = SEL_W'((pos >= N) ? pos - N : pos);
   end

endmodule

// File: rtl/stream_sel_mux.sv
// N:1 stream selector with a registered output stage; channel chosen by
// external select or round-robin, optionally locked to the last source.
module stream_sel_mux
   import stream_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 8,
   parameter int unsigned SEL_W = $clog2(N),
   parameter int unsigned MODE  = MODE_SEL
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   input  logic [SEL_W-1:0]   sel,
   input  logic               lock,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_src,
   input  logic               out_ready
);

   logic [SEL_W-1:0] rr_ptr;
   logic             locked;
   logic [SEL_W-1:0] lock_src;

   logic [SEL_W-1:0] rr_idx;
   logic             rr_any;
   logic             ld;
   logic             sel_ok;
   logic [SEL_W-1:0] sel_idx;
   logic [SEL_W-1:0] g;
   logic             gx;
   logic             xfer;
   logic [WIDTH-1:0] g_data;

   rr_pick #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_pick (
      .req     (in_valid),
      .ptr     (rr_ptr),
      .gnt_idx (rr_idx),
      .gnt_any (rr_any)
   );

   assign ld = !out_valid || out_ready;

   // Out-of-range select is steered to index 0 and masked, so in_valid is
   // never indexed past N-1.
   always_comb begin
      sel_ok  = (32'(sel) < N);
      sel_idx = sel_ok ? sel : '0;
      g       = '0;
      gx      = 1'b0;
      if (locked) begin
         g  = lock_src;
         gx = in_valid[lock_src];
      end else if (MODE == MODE_RR) begin
         g  = rr_idx;
         gx = rr_any;
      end else begin
         g  = sel_idx;
         gx = sel_ok && in_valid[sel_idx];
      end
   end

   always_comb begin
      xfer        = rst_n && ld && gx;
      in_ready    = '0;
      in_ready[g] = xfer;
      g_data      = in_data[g*WIDTH +: WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         rr_ptr    <= '0;
         locked    <= 1'b0;
         lock_src  <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= g_data;
         out_src   <= g;
         if (lock) begin
            locked   <= 1'b1;
            lock_src <= g;
         end else begin
            locked <= 1'b0;
            if (MODE == MODE_RR) begin
               rr_ptr <= SEL_W'(rr_next(32'(g), N));
            end
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_sel_mux.sv
// Directed bench for stream_sel_mux: select mode, round-robin, backpressure,
// lock, out-of-range select on N=5, and asynchronous reset mid-stream.
module tb_stream_sel_mux;
   import stream_pkg::*;

   typedef struct {
      logic [31:0] d;
      logic [2:0]  s;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // DUT a: MODE=0, N=8
   logic [7:0]   a_valid, a_ready;
   logic [255:0] a_data;
   logic [2:0]   a_sel, a_src;
   logic         a_lock, a_ov, a_or;
   logic [31:0]  a_od;
   // DUT b: MODE=1, N=8
   logic [7:0]   b_valid, b_ready;
   logic [255:0] b_data;
   logic [2:0]   b_sel, b_src;
   logic         b_lock, b_ov, b_or;
   logic [31:0]  b_od;
   // DUT c: MODE=0, N=5
   logic [4:0]   c_valid, c_ready;
   logic [159:0] c_data;
   logic [2:0]   c_sel, c_src;
   logic         c_lock, c_ov, c_or;
   logic [31:0]  c_od;

   stream_sel_mux #(.WIDTH(32), .N(8), .MODE(MODE_SEL)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
      .sel(a_sel), .lock(a_lock), .out_valid(a_ov), .out_data(a_od), .out_src(a_src),
      .out_ready(a_or));

   stream_sel_mux #(.WIDTH(32), .N(8), .MODE(MODE_RR)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
      .sel(b_sel), .lock(b_lock), .out_valid(b_ov), .out_data(b_od), .out_src(b_src),
      .out_ready(b_or));

   stream_sel_mux #(.WIDTH(32), .N(5), .MODE(MODE_SEL)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_data(c_data), .in_ready(c_ready),
      .sel(c_sel), .lock(c_lock), .out_valid(c_ov), .out_data(c_od), .out_src(c_src),
      .out_ready(c_or));

   int unsigned total = 0;
   int unsigned bad   = 0;
   beat_t       qb[$];
   beat_t       qa[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] bd(input int unsigned ch, input int unsigned k);
      return 32'hB000_0000 | (k << 8) | ch;
   endfunction

   task automatic set_b_data(input int unsigned k);
      for (int unsigned i = 0; i < 8; i++) b_data[i*32 +: 32] = bd(i, k);
   endtask

   task automatic push_b(input int unsigned ch, input int unsigned k);
      beat_t e;
      e.d = bd(ch, k);
      e.s = 3'(ch);
      qb.push_back(e);
   endtask

   task automatic pop_b(input string tag);
      beat_t e;
      total++;
      assert (qb.size() != 0) else begin
         bad++;
         $error("FAIL %s_sb observed=empty expected=beat", tag);
      end
      if (qb.size() != 0) begin
         e = qb.pop_front();
         chk({tag, "_ov"}, 64'(b_ov), 64'd1);
         chk({tag, "_od"}, 64'(b_od), 64'(e.d));
         chk({tag, "_src"}, 64'(b_src), 64'(e.s));
      end
   endtask

   initial begin
      beat_t ea;
      rst_n = 1'b0;
      a_valid = '0; a_data = '0; a_sel = '0; a_lock = 1'b0; a_or = 1'b1;
      b_valid = '0; b_data = '0; b_sel = '0; b_lock = 1'b0; b_or = 1'b1;
      c_valid = '0; c_data = '0; c_sel = '0; c_lock = 1'b0; c_or = 1'b1;
      #1;
      // reset state, and in_ready held low while in reset
      a_valid = 8'h01;
      b_valid = 8'hFF;
      #1;
      chk("rst_a_ready", 64'(a_ready), 64'h0);
      chk("rst_b_ready", 64'(b_ready), 64'h0);
      chk("rst_a_ov", 64'(a_ov), 64'h0);
      chk("rst_b_od", 64'(b_od), 64'h0);
      chk("rst_b_src", 64'(b_src), 64'h0);
      a_valid = '0;
      b_valid = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: external select of channel 5
      a_sel = 3'd5;
      a_valid = 8'h20;
      a_data[5*32 +: 32] = 32'hDEADBEEF;
      #1;
      chk("sel5_ready", 64'(a_ready), 64'h20);
      ea.d = 32'hDEADBEEF; ea.s = 3'd5;
      qa.push_back(ea);
      step();
      ea = qa.pop_front();
      chk("sel5_ov", 64'(a_ov), 64'd1);
      chk("sel5_od", 64'(a_od), 64'(ea.d));
      chk("sel5_src", 64'(a_src), 64'(ea.s));
      a_valid = '0;
      #1;
      chk("sel5_idle_ready", 64'(a_ready), 64'h0);
      step();
      chk("sel5_drain_ov", 64'(a_ov), 64'd0);
      chk("sel5_hold_od", 64'(a_od), 64'hDEADBEEF);

      // 5: N=5, select beyond channel count
      c_sel = 3'd6;
      c_valid = 5'h1F;
      for (int unsigned i = 0; i < 5; i++) c_data[i*32 +: 32] = 32'hC000_0000 | i;
      #1;
      chk("n5_sel6_ready", 64'(c_ready), 64'h0);
      step();
      chk("n5_sel6_ov", 64'(c_ov), 64'd0);
      chk("n5_sel6_od", 64'(c_od), 64'h0);
      chk("n5_sel6_src", 64'(c_src), 64'h0);
      c_sel = 3'd4;
      #1;
      chk("n5_sel4_ready", 64'(c_ready), 64'h10);
      step();
      chk("n5_sel4_ov", 64'(c_ov), 64'd1);
      chk("n5_sel4_od", 64'(c_od), 64'hC000_0004);
      chk("n5_sel4_src", 64'(c_src), 64'd4);
      c_sel = 3'd5;
      #1;
      chk("n5_sel5_ready", 64'(c_ready), 64'h0);
      step();
      chk("n5_sel5_ov", 64'(c_ov), 64'd0);
      chk("n5_sel5_src", 64'(c_src), 64'd4);

      // 2: round-robin over all-valid channels, 16 beats
      b_valid = 8'hFF;
      for (int unsigned k = 0; k < 16; k++) begin
         set_b_data(k);
         #1;
         chk("rr_ready", 64'(b_ready), 64'(8'h01 << (k % 8)));
         push_b(k % 8, k);
         step();
         pop_b("rr");
      end

      // 3: backpressure for 3 cycles with fresh inputs
      b_or = 1'b0;
      set_b_data(16);
      for (int unsigned k = 0; k < 3; k++) begin
         #1;
         chk("bp_ready", 64'(b_ready), 64'h0);
         step();
         chk("bp_ov", 64'(b_ov), 64'd1);
         chk("bp_od", 64'(b_od), 64'(bd(7, 15)));
         chk("bp_src", 64'(b_src), 64'd7);
      end
      b_or = 1'b1;
      set_b_data(20);
      #1;
      chk("bp_rel_ready", 64'(b_ready), 64'h01);
      push_b(0, 20);
      step();
      pop_b("bp_rel");
      b_valid = '0;
      #1;
      chk("bp_after_ready", 64'(b_ready), 64'h0);
      step();
      chk("bp_after_ov", 64'(b_ov), 64'd0);

      // 4: lock on channel 2 blocks channel 3 until released
      b_valid = 8'h04;
      b_lock = 1'b1;
      set_b_data(30);
      #1;
      chk("lk_acc_ready", 64'(b_ready), 64'h04);
      push_b(2, 30);
      step();
      pop_b("lk_acc");
      b_lock = 1'b0;
      b_valid = 8'h08;
      for (int unsigned k = 0; k < 2; k++) begin
         #1;
         chk("lk_block_ready", 64'(b_ready), 64'h0);
         step();
         chk("lk_block_ov", 64'(b_ov), 64'd0);
      end
      b_valid = 8'h0C;
      set_b_data(31);
      #1;
      chk("lk_rel_ready", 64'(b_ready), 64'h04);
      push_b(2, 31);
      step();
      pop_b("lk_rel");
      set_b_data(32);
      #1;
      chk("lk_next_ready", 64'(b_ready), 64'h08);
      push_b(3, 32);
      step();
      pop_b("lk_next");

      // 6: async reset while holding a locked beat under stall
      b_valid = 8'h30;
      b_lock = 1'b1;
      set_b_data(40);
      #1;
      chk("rs_acc_ready", 64'(b_ready), 64'h10);
      push_b(4, 40);
      step();
      pop_b("rs_acc");
      b_or = 1'b0;
      b_lock = 1'b0;
      b_valid = 8'h20;
      step();
      chk("rs_stall_ov", 64'(b_ov), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rs_async_ov", 64'(b_ov), 64'd0);
      chk("rs_async_od", 64'(b_od), 64'h0);
      chk("rs_async_src", 64'(b_src), 64'h0);
      chk("rs_async_ready", 64'(b_ready), 64'h0);
      qb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      b_or = 1'b1;
      b_valid = 8'hFF;
      for (int unsigned k = 0; k < 2; k++) begin
         set_b_data(41 + k);
         #1;
         chk("rs_resume_ready", 64'(b_ready), 64'(8'h01 << k));
         push_b(k, 41 + k);
         step();
         pop_b("rs_resume");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
